// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM    = 3'd2,
        MULDIV = 3'd3,
        HALTED = 3'd4
    } seq_state_t;

    localparam logic [31:0] HALT_ADDR = 32'h0000_0000;

    // States in which a bus transfer is outstanding and the watchdog may run.
    function automatic logic is_bus_state(input seq_state_t s);
        return (s == FETCH) || (s == MEM);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus, decoder and control signals between the sequencer and the rest of the core.
interface cpu_sequencer_if #(
    parameter int CNT_W = 32
);

    logic             waitrequest;
    logic             data_read;
    logic             data_write;
    logic             muldiv_start;
    logic             muldiv_done;
    logic             pc_zero;
    logic             bus_read;
    logic             bus_write;
    logic             addr_sel_data;
    logic             ir_wren;
    logic             pc_wren;
    logic             reg_commit;
    logic             muldiv_go;
    logic             active;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  waitrequest, data_read, data_write, muldiv_start, muldiv_done, pc_zero,
        output bus_read, bus_write, addr_sel_data, ir_wren, pc_wren, reg_commit,
        output muldiv_go, active, fault, retired
    );

    modport slave (
        output waitrequest, data_read, data_write, muldiv_start, muldiv_done, pc_zero,
        input  bus_read, bus_write, addr_sel_data, ir_wren, pc_wren, reg_commit,
        input  muldiv_go, active, fault, retired
    );

endinterface

// File: rtl/cpu_sequencer_bus_watchdog.sv
// Saturating counter of consecutive stalled bus cycles; expired once MAX_WAIT is reached.
module bus_watchdog #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != CW'(MAX_WAIT))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CW'(MAX_WAIT));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer: fetch, execute, optional memory or mul/div wait, then commit.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus
);

    seq_state_t       state_q, state_d;
    logic             active_q, active_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic rd_c, wr_c, asd_c, ir_c, pc_c, rc_c, go_c;
    logic wd_count_en, wd_expired;

    assign wd_count_en = is_bus_state(state_q) && bus.waitrequest;

    bus_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .count_en (wd_count_en),
        .clear    (!wd_count_en),
        .expired  (wd_expired)
    );

    // Strobes are Mealy on waitrequest/muldiv_done and held low while reset is high.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        asd_c   = 1'b0;
        ir_c    = 1'b0;
        pc_c    = 1'b0;
        rc_c    = 1'b0;
        go_c    = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    if (wd_expired) begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else if (bus.pc_zero) begin
                        state_d = HALTED;
                    end else begin
                        rd_c = 1'b1;
                        if (!bus.waitrequest) begin
                            ir_c    = 1'b1;
                            state_d = EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (bus.data_read || bus.data_write) begin
                        state_d = MEM;
                    end else if (bus.muldiv_start) begin
                        go_c    = 1'b1;
                        state_d = MULDIV;
                    end else begin
                        rc_c    = 1'b1;
                        pc_c    = 1'b1;
                        state_d = FETCH;
                    end
                end
                MEM: begin
                    if (wd_expired) begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else begin
                        // A malformed read+write instruction is treated as a load.
                        asd_c = 1'b1;
                        rd_c  = bus.data_read;
                        wr_c  = bus.data_write && !bus.data_read;
                        if (!bus.waitrequest) begin
                            rc_c    = bus.data_read;
                            pc_c    = 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                MULDIV: begin
                    if (bus.muldiv_done) begin
                        pc_c    = 1'b1;
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = HALTED;
                end
            endcase
        end
        active_d  = (state_d != HALTED);
        retired_d = retired_q + CNT_W'(pc_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            active_q  <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign bus.bus_read      = rd_c;
    assign bus.bus_write     = wr_c;
    assign bus.addr_sel_data = asd_c;
    assign bus.ir_wren       = ir_c;
    assign bus.pc_wren       = pc_c;
    assign bus.reg_commit    = rc_c;
    assign bus.muldiv_go     = go_c;
    assign bus.active        = active_q;
    assign bus.fault         = fault_q;
    assign bus.retired       = retired_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle state machine that sequences the MIPS core's datapath: it fetches each instruction over the shared memory bus, hands the decoded word to the combinational control decoder, runs the execute step, and performs the optional data access or multiply/divide wait before committing. It owns the single memory bus port, choosing between instruction and data addresses. It drives the register-file, PC and IR write strobes. It also detects halt and bus-timeout conditions.

## Interface
Parameters:
- MAX_WAIT, default 255: consecutive waitrequest cycles tolerated before a bus fault.
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- waitrequest  in  1  bus stall; a transfer completes on the first cycle it is 0 while a strobe is high.
- data_read  in  1  decoder: current instruction is a load.
- data_write  in  1  decoder: current instruction is a store.
- muldiv_start  in  1  decoder: current instruction is MULT/MULTU/DIV/DIVU.
- muldiv_done  in  1  multiply/divide unit result ready; level signal.
- pc_zero  in  1  next PC equals 0x00000000; this is the halt condition.
- bus_read  out  1  memory read strobe.
- bus_write  out  1  memory write strobe.
- addr_sel_data  out  1  1 selects the ALU data address, 0 selects the PC.
- ir_wren  out  1  latch readdata into IR.
- pc_wren  out  1  advance the PC; one pulse per retired instruction.
- reg_commit  out  1  register-file write enable qualifier, ANDed with the decoder's reg_wren.
- muldiv_go  out  1  one-cycle start pulse to the multiply/divide unit.
- active  out  1  high from reset release until halt or fault.
- fault  out  1  sticky bus-timeout flag.
- retired  out  CNT_W  count of retired instructions.

## Operation
States: FETCH, EXEC, MEM, MULDIV, HALTED.

- **FETCH**
  - If pc_zero=1: go to HALTED without issuing a read.
  - Otherwise: bus_read=1, addr_sel_data=0.
  - On waitrequest=0: ir_wren=1, go to EXEC.
- **EXEC**
  - If data_read or data_write: go to MEM.
  - Else if muldiv_start: muldiv_go=1, go to MULDIV.
  - Otherwise: reg_commit=1, pc_wren=1, go to FETCH.
- **MEM**
  - addr_sel_data=1; bus_read=data_read, bus_write=data_write.
  - On waitrequest=0: reg_commit=data_read, pc_wren=1, go to FETCH.
- **MULDIV**
  - On muldiv_done=1: pc_wren=1, go to FETCH.
  - HI/LO writes belong to the multiply/divide unit.
- **HALTED**
  - active=0 and all strobes 0. Exit only on reset.

Watchdog and fault:
- The watchdog counts consecutive cycles in FETCH or MEM with waitrequest=1. It clears on any other cycle.
- When the count reaches MAX_WAIT: fault=1, go to HALTED, and drop strobes on that same cycle.

Retired counter:
- retired increments on every pc_wren and wraps modulo 2^CNT_W.
- Jumps and branches are retired like any other instruction; target selection is the PC logic's job.

Precedence: reset > watchdog fault > pc_zero > normal transitions. data_read and data_write are never both 1; if they are, treat the instruction as a read.

## Timing
Reset behaviour:
- While reset is high: state=FETCH, active=0, fault=0, retired=0, watchdog=0.
- All strobe outputs are forced 0 combinationally while reset is high.
- active rises on the first clk edge after reset falls.
- Reset asserted mid-transfer aborts the transfer immediately; no pc_wren and no reg_commit are issued.

Output timing:
- Strobes are combinational from state and inputs (Mealy on waitrequest and muldiv_done).
- state, active, fault, retired and watchdog are registered.

Latency with zero wait states:
- ALU or jump instruction: 2 cycles.
- Load or store: 3 cycles.
- Multiply/divide: 2 cycles plus the unit's latency; if muldiv_done is already high in the cycle after EXEC, 3 cycles total.

Each waitrequest=1 cycle adds exactly one cycle. Bus strobes and the address stay stable while waitrequest=1.

## Structure
Shared package cpu_pkg holds:
- typedef enum seq_state_t with encodings FETCH=0, EXEC=1, MEM=2, MULDIV=3, HALTED=4;
- the HALT_ADDR constant (0x00000000).

The watchdog is one sub-module, bus_watchdog: a counter with MAX_WAIT and inputs count_en and clear, and output expired.

## Test plan
- Reset, then a single ADDU with waitrequest=0 → cycle 1 ir_wren, cycle 2 reg_commit and pc_wren; retired=1; active=1.
- LW with 2 waitrequest cycles in MEM → 5 cycles total; bus_read and addr_sel_data=1 held for 3 cycles; reg_commit only on the final cycle.
- SW with waitrequest=0 → bus_write=1 for exactly 1 cycle in MEM; reg_commit stays 0; pc_wren=1.
- MULT with muldiv_done rising 4 cycles after EXEC → muldiv_go pulses once; pc_wren on the done cycle; no reg_commit.
- JR to 0 → retired increments; next FETCH sees pc_zero=1 and goes to HALTED; active=0; no further bus_read.
- MAX_WAIT=4 with waitrequest stuck at 1 in FETCH → fault=1 and HALTED after 4 stalled cycles; asserting reset clears fault and resumes FETCH.
